jtkiwi_shr_arb: RTL and testbench

Arbiter for the 8kB communication RAM shared between the main Z80 and the sub (sound/MCU) CPU. It replaces a true dual-port RAM with one single-port RAM. Each access is serialized, one at a time. Each CPU sees a busy signal, which it feeds to the devwait/dev_busy input of its Z80 wrapper, so bus contention is modelled cycle-accurately. Round-robin on simultaneous requests; fixed 3-cycle service latency.

---
 rtl/jtkiwi_arb_pkg.sv | 31 +++
 rtl/jtkiwi_arb_port.sv | 34 +++
 rtl/jtkiwi_shr_arb.sv | 119 +++++++++++
 tb/tb_jtkiwi_shr_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkiwi_arb_pkg.sv
// Shared definitions for the comm-RAM arbiter: FSM states, requester ids,
// grant encodings and the round-robin pick rule.
package jtkiwi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    REQ_MAIN = 1'b0,
    REQ_SUB  = 1'b1
  } req_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_MAIN = 2'b01;
  localparam logic [1:0] GNT_SUB  = 2'b10;

  // A tie goes to whichever requester did not win the previous grant.
  function automatic req_t arb_pick(input logic main_pend, input logic sub_pend,
                                    input req_t last);
    if (main_pend && sub_pend) return (last == REQ_MAIN) ? REQ_SUB : REQ_MAIN;
    return sub_pend ? REQ_SUB : REQ_MAIN;
  endfunction

  function automatic logic [1:0] gnt_of(input req_t who);
    return (who == REQ_SUB) ? GNT_SUB : GNT_MAIN;
  endfunction

endpackage

// File: rtl/jtkiwi_arb_port.sv
// Per-requester side of the arbiter: done flag, registered read data and the
// busy line that stalls the CPU until its single access has been served.
module jtkiwi_arb_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          fin,
  input  logic          rd,
  input  logic [DW-1:0] ram_dout,
  output logic          done,
  output logic [DW-1:0] dout,
  output logic          busy
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      dout <= '0;
    end else begin
      // done sticks while cs is held, enforcing one access per assertion.
      if (!cs)      done <= 1'b0;
      else if (fin) done <= 1'b1;
      if (fin && rd) dout <= ram_dout;
    end
  end

  // Reset is folded in so a CPU holding cs through reset is not stalled.
  assign busy = cs & ~done & rst_n;

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// Serialises main and sub CPU accesses onto one single-port 8kB comm RAM,
// round-robin on ties, with a fixed three-cycle service per access.
module jtkiwi_shr_arb
  import jtkiwi_arb_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_busy,
  input  logic          sub_cs,
  input  logic          sub_we,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    gnt
);

  state_t state;
  req_t   last;
  logic   acc_rd;
  logic   main_done, sub_done;
  logic   main_pend, sub_pend;
  logic   main_fin, sub_fin;
  req_t   win;

  assign main_pend = main_cs & ~main_done;
  assign sub_pend  = sub_cs  & ~sub_done;
  assign win       = arb_pick(main_pend, sub_pend, last);

  // Completion only counts if the granted requester still holds cs; an
  // early drop discards the read and leaves done clear.
  assign main_fin = (state == DATA) && (gnt == GNT_MAIN) && main_cs;
  assign sub_fin  = (state == DATA) && (gnt == GNT_SUB)  && sub_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= REQ_SUB;
      acc_rd   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      gnt      <= GNT_NONE;
    end else begin
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (main_pend || sub_pend) begin
            if (win == REQ_SUB) begin
              ram_addr <= sub_addr;
              ram_din  <= sub_din;
              ram_we   <= sub_we;
              acc_rd   <= ~sub_we;
            end else begin
              ram_addr <= main_addr;
              ram_din  <= main_din;
              ram_we   <= main_we;
              acc_rd   <= ~main_we;
            end
            gnt   <= gnt_of(win);
            last  <= win;
            state <= ACC;
          end
        end
        ACC: begin
          // The RAM write is issued here and cannot be withdrawn by an abort.
          ram_we <= 1'b0;
          state  <= DATA;
        end
        DATA: begin
          gnt   <= GNT_NONE;
          state <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          gnt    <= GNT_NONE;
          state  <= IDLE;
        end
      endcase
    end
  end

  jtkiwi_arb_port #(.DW(DW)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (main_cs),
    .fin      (main_fin),
    .rd       (acc_rd),
    .ram_dout (ram_dout),
    .done     (main_done),
    .dout     (main_dout),
    .busy     (main_busy)
  );

  jtkiwi_arb_port #(.DW(DW)) u_sub (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (sub_cs),
    .fin      (sub_fin),
    .rd       (acc_rd),
    .ram_dout (ram_dout),
    .done     (sub_done),
    .dout     (sub_dout),
    .busy     (sub_busy)
  );

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Directed bench for the comm-RAM arbiter: a vector table of single and tied
// accesses, then hand-written contention, abort and mid-access reset cases.
module tb_jtkiwi_shr_arb;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          main_cs, main_we, sub_cs, sub_we;
  logic [AW-1:0] main_addr, sub_addr;
  logic [DW-1:0] main_din, sub_din;
  logic [DW-1:0] main_dout, sub_dout;
  logic          main_busy, sub_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [1:0]    gnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtkiwi_shr_arb #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .main_cs   (main_cs),
    .main_we   (main_we),
    .main_addr (main_addr),
    .main_din  (main_din),
    .main_dout (main_dout),
    .main_busy (main_busy),
    .sub_cs    (sub_cs),
    .sub_we    (sub_we),
    .sub_addr  (sub_addr),
    .sub_din   (sub_din),
    .sub_dout  (sub_dout),
    .sub_busy  (sub_busy),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .gnt       (gnt)
  );

  // Synchronous single-port RAM model, read data one cycle after address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      mem[13'h0123] <= 8'h5A;
      mem[13'h0456] <= 8'h77;
      ram_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          do_main, do_sub;
    logic          main_we, sub_we;
    logic [AW-1:0] main_addr, sub_addr;
    logic [DW-1:0] main_din, sub_din;
    logic [1:0]    exp_gnt;
    logic [AW-1:0] exp_addr;
    int            exp_main_lat, exp_sub_lat;  // 0 = not requested, busy must stay low
    logic [DW-1:0] exp_main_dout, exp_sub_dout;
  } vec_t;

  vec_t vecs [7];

  // Raise the requested cs lines together just after an edge, record when
  // each busy falls (in cycles), and release cs as a CPU would.
  task automatic apply(input vec_t v, input int idx);
    int  ml, sl;
    bit  mseen, sseen;
    ml = 0; sl = 0; mseen = 0; sseen = 0;
    @(posedge clk); #1;
    main_cs = v.do_main; main_we = v.main_we; main_addr = v.main_addr; main_din = v.main_din;
    sub_cs  = v.do_sub;  sub_we  = v.sub_we;  sub_addr  = v.sub_addr;  sub_din  = v.sub_din;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("v%0d gnt", idx), 32'(gnt), 32'(v.exp_gnt));
        check($sformatf("v%0d ram_addr", idx), 32'(ram_addr), 32'(v.exp_addr));
      end
      if (main_busy) mseen = 1;
      if (sub_busy)  sseen = 1;
      if (main_cs && !main_busy && ml == 0) begin ml = c; main_cs = 1'b0; end
      if (sub_cs  && !sub_busy  && sl == 0) begin sl = c; sub_cs  = 1'b0; end
    end
    if (!v.do_main && mseen) ml = 99;
    if (!v.do_sub  && sseen) sl = 99;
    if (v.do_main && ml == 0) ml = 98;
    if (v.do_sub  && sl == 0) sl = 98;
    main_cs = 1'b0; sub_cs = 1'b0;
    check($sformatf("v%0d main latency", idx), 32'(ml), 32'(v.exp_main_lat));
    check($sformatf("v%0d sub latency", idx),  32'(sl), 32'(v.exp_sub_lat));
    check($sformatf("v%0d main_dout", idx), 32'(main_dout), 32'(v.exp_main_dout));
    check($sformatf("v%0d sub_dout", idx),  32'(sub_dout),  32'(v.exp_sub_dout));
    repeat (2) @(negedge clk);
  endtask

  // Counts the widest ram_we pulse seen over the whole run.
  int we_run = 0, we_max = 0;
  always @(negedge clk) begin
    if (ram_we) we_run++; else we_run = 0;
    if (we_run > we_max) we_max = we_run;
  end

  initial begin
    int  m_run, s_run, m_max, s_max, accesses, alt_err, cyc, lat;
    logic [1:0] prev_g, last_g;
    bit  done_seen, we_seen;

    //            main  sub   mwe   swe   maddr     saddr     mdin   sdin   gnt1   addr1     ml sl mdout  sdout
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 13'h0123, 13'h0456, 8'h00, 8'h00, 2'b01, 13'h0123, 3, 6, 8'h5A, 8'h77};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 13'h0200, 13'h0000, 8'h11, 8'h00, 2'b01, 13'h0200, 3, 0, 8'h5A, 8'h77};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 13'h0200, 13'h1FFF, 8'h00, 8'hC3, 2'b10, 13'h1FFF, 6, 3, 8'h11, 8'h77};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 13'h0000, 13'h1FFF, 8'h00, 8'h00, 2'b10, 13'h1FFF, 0, 3, 8'h11, 8'hC3};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 13'h0123, 13'h0200, 8'hA5, 8'h00, 2'b01, 13'h0123, 3, 6, 8'h11, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 13'h0123, 13'h0000, 8'h00, 8'h00, 2'b01, 13'h0123, 3, 0, 8'hA5, 8'h11};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 13'h0000, 13'h0000, 8'h00, 8'h00, 2'b10, 13'h0000, 0, 3, 8'hA5, 8'h00};

    // Reset with main_cs already high: busy must still read low.
    rst_n = 1'b0;
    main_cs = 1'b1; main_we = 1'b0; main_addr = '0; main_din = '0;
    sub_cs = 1'b0;  sub_we = 1'b0;  sub_addr = '0;  sub_din = '0;
    repeat (3) @(negedge clk);
    check("reset main_busy", 32'(main_busy), 32'd0);
    check("reset ram_we",    32'(ram_we),    32'd0);
    check("reset ram_addr",  32'(ram_addr),  32'd0);
    check("reset gnt",       32'(gnt),       32'd0);
    check("reset main_dout", 32'(main_dout), 32'd0);
    check("reset sub_dout",  32'(sub_dout),  32'd0);
    main_cs = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) apply(vecs[i], i);
    check("ram 0x1FFF written", 32'(mem[13'h1FFF]), 32'hC3);

    // Continuous contention: each side re-raises cs one cycle after release.
    m_run = 0; s_run = 0; m_max = 0; s_max = 0; accesses = 0; alt_err = 0;
    prev_g = 2'b00; last_g = 2'b00; cyc = 0;
    main_we = 1'b0; main_addr = 13'h0123; sub_we = 1'b0; sub_addr = 13'h0200;
    @(posedge clk); #1; main_cs = 1'b1; sub_cs = 1'b1;
    while (accesses < 100 && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (gnt != 2'b00 && prev_g == 2'b00) begin
        if (gnt == last_g) alt_err++;
        last_g = gnt;
      end
      prev_g = gnt;
      if (main_busy) m_run++; else m_run = 0;
      if (sub_busy)  s_run++; else s_run = 0;
      if (m_run > m_max) m_max = m_run;
      if (s_run > s_max) s_max = s_run;
      if (main_cs && !main_busy) begin main_cs = 1'b0; accesses++; end
      else if (!main_cs) main_cs = 1'b1;
      if (sub_cs && !sub_busy) begin sub_cs = 1'b0; accesses++; end
      else if (!sub_cs) sub_cs = 1'b1;
    end
    main_cs = 1'b0; sub_cs = 1'b0;
    check("contention completed", 32'(accesses >= 100), 32'd1);
    check("contention alternation errors", 32'(alt_err), 32'd0);
    check("contention main busy max<=6", 32'(m_max <= 6), 32'd1);
    check("contention sub busy max<=6",  32'(s_max <= 6), 32'd1);
    check("contention main_dout", 32'(main_dout), 32'hA5);
    check("contention sub_dout",  32'(sub_dout),  32'h11);
    repeat (3) @(negedge clk);

    // Abort a main read during ACC: data discarded, done never set.
    done_seen = 0;
    @(posedge clk); #1;
    main_cs = 1'b1; main_we = 1'b0; main_addr = 13'h0456;
    @(negedge clk); @(negedge clk);
    check("abort read gnt in ACC", 32'(gnt), 32'(2'b01));
    main_cs = 1'b0;
    repeat (5) begin @(negedge clk); if (dut.u_main.done) done_seen = 1; end
    check("abort read main_dout", 32'(main_dout), 32'hA5);
    check("abort read done", 32'(done_seen), 32'd0);
    check("abort read main_busy", 32'(main_busy), 32'd0);

    // Abort a main write during ACC: the write is still committed.
    @(posedge clk); #1;
    main_cs = 1'b1; main_we = 1'b1; main_addr = 13'h0789; main_din = 8'h3C;
    @(negedge clk); @(negedge clk);
    check("abort write ram_we in ACC", 32'(ram_we), 32'd1);
    main_cs = 1'b0;
    repeat (4) @(negedge clk);
    check("abort write ram updated", 32'(mem[13'h0789]), 32'h3C);
    check("abort write main_dout", 32'(main_dout), 32'hA5);

    // Reset during ACC of a sub write, then restart once released.
    @(posedge clk); #1;
    sub_cs = 1'b1; sub_we = 1'b1; sub_addr = 13'h0300; sub_din = 8'h99;
    @(negedge clk); @(negedge clk);
    check("pre-reset ram_we", 32'(ram_we), 32'd1);
    rst_n = 1'b0; #1;
    check("async reset ram_we", 32'(ram_we), 32'd0);
    check("async reset gnt", 32'(gnt), 32'd0);
    check("async reset sub_busy", 32'(sub_busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    lat = 0; we_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1 && ram_we) we_seen = 1;
      if (lat == 0 && !sub_busy) lat = c;
    end
    sub_cs = 1'b0;
    check("restart ram_we at +1", 32'(we_seen), 32'd1);
    check("restart latency", 32'(lat), 32'd3);
    repeat (2) @(negedge clk);
    check("restart ram updated", 32'(mem[13'h0300]), 32'h99);
    check("ram_we pulse width", 32'(we_max), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
